data_mem_arbiter: RTL

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/data_mem_arbiter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/data_mem_arbiter.sv
// Two-requester arbiter in front of a bram32 (separate write and read ports, 1-cycle read latency).
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default is req0 priority with a bounded req1 wait.
`ifndef RAM_ADDR_WIDTH
`define RAM_ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module data_mem_arbiter #(
   parameter int AW       = `RAM_ADDR_WIDTH,
   parameter int DW       = `DATA_WIDTH,
   parameter int MAX_HOLD = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req0_valid,
   output logic          req0_ready,
   input  logic          req0_we,
   input  logic [AW-1:0] req0_addr,
   input  logic [DW-1:0] req0_wdat,
   input  logic [3:0]    req0_be,
   output logic          req0_rvalid,
   output logic [DW-1:0] req0_rdat,
   input  logic          req1_valid,
   output logic          req1_ready,
   input  logic          req1_we,
   input  logic [AW-1:0] req1_addr,
   input  logic [DW-1:0] req1_wdat,
   input  logic [3:0]    req1_be,
   output logic          req1_rvalid,
   output logic [DW-1:0] req1_rdat,
   output logic [AW-1:0] m_w_addr,
   output logic [DW-1:0] m_w_dat,
   output logic          m_w_enb,
   output logic [3:0]    m_byte_enb,
   output logic [AW-1:0] m_r_addr,
   output logic          m_r_enb,
   input  logic [DW-1:0] m_r_dat
);

   typedef enum logic {LAST0 = 1'b0, LAST1 = 1'b1} last_t;

   last_t         last_grant, last_grant_nxt;
   logic          gnt1;
   logic          accept;
   logic          sel_we;
   logic [AW-1:0] sel_addr;
   logic          rd_vld_p0;
   logic          rd_own_p0;

`ifndef ARB_ROUND_ROBIN_EN
   localparam int            HW       = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
   logic [HW-1:0] hold_cnt, hold_nxt;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant <= LAST1;
`ifndef ARB_ROUND_ROBIN_EN
         hold_cnt   <= '0;
`endif
      end else begin
         last_grant <= last_grant_nxt;
`ifndef ARB_ROUND_ROBIN_EN
         hold_cnt   <= hold_nxt;
`endif
      end
   end

   always_comb begin
      gnt1 = req1_valid;
      if (req0_valid && req1_valid) begin
`ifdef ARB_ROUND_ROBIN_EN
         gnt1 = (last_grant == LAST0);
`else
         gnt1 = (hold_cnt == HOLD_MAX);
`endif
      end

      req0_ready = ~rst & req0_valid & ~gnt1;
      req1_ready = ~rst & req1_valid & gnt1;
      accept     = req0_ready | req1_ready;

      sel_we     = gnt1 ? req1_we   : req0_we;
      sel_addr   = gnt1 ? req1_addr : req0_addr;
      m_w_addr   = sel_addr;
      m_r_addr   = sel_addr;
      m_w_dat    = gnt1 ? req1_wdat : req0_wdat;
      m_byte_enb = gnt1 ? req1_be   : req0_be;
      m_w_enb    = accept & sel_we;
      m_r_enb    = accept & ~sel_we;

      last_grant_nxt = last_grant;
      if (accept) last_grant_nxt = gnt1 ? LAST1 : LAST0;

`ifndef ARB_ROUND_ROBIN_EN
      // Counts req0 wins only while req1 is actually waiting.
      hold_nxt = hold_cnt;
      if (!req1_valid || req1_ready)
         hold_nxt = '0;
      else if (req0_ready && hold_cnt != HOLD_MAX)
         hold_nxt = hold_cnt + 1'b1;
`endif
   end

   // p0: bram read in flight; owner travels with it to route the returning data
   always_ff @(posedge clk) begin
      if (rst) rd_vld_p0 <= 1'b0;
      else     rd_vld_p0 <= m_r_enb;
      rd_own_p0 <= gnt1;
   end

   assign req0_rvalid = rd_vld_p0 & ~rd_own_p0 & ~rst;
   assign req1_rvalid = rd_vld_p0 &  rd_own_p0 & ~rst;
   assign req0_rdat   = req0_rvalid ? m_r_dat : '0;
   assign req1_rdat   = req1_rvalid ? m_r_dat : '0;

endmodule
